mod_midi_rx: RTL and testbench

- Serial MIDI byte receiver: 8N1 asynchronous framing, LSB first, 31250 baud.
- Sits directly upstream of mod_byte_display; its o_held_byte drives the display's i_value, so the last good MIDI byte shows as two hex digits.
- o_data/o_valid also feed downstream MIDI parsing logic.

---
 rtl/midi_pkg.sv | 6 +
 rtl/mod_sync2.sv | 23 ++
 rtl/mod_midi_rx.sv | 119 +++++++++++
 tb/tb_mod_midi_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI types: receiver state encoding, bit rate and the byte type.
package midi_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} midi_rx_state_t;
  localparam int MIDI_BAUD = 31250;
  typedef logic [7:0] midi_byte_t;
endpackage

// File: rtl/mod_sync2.sv
// Two-flop synchronizer for an asynchronous pin; reset value selects the idle level.
module mod_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/mod_midi_rx.sv
// MIDI 8N1 serial receiver, LSB first; held byte feeds the hex byte display.
module mod_midi_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = MIDI_BAUD,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic [7:0] o_held_byte,
  output logic       o_busy
);
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("mod_midi_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  localparam int CW = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic           rx_s;
  midi_rx_state_t state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  midi_byte_t     sh_q, data_q, held_q;
  logic           valid_q, ferr_q;

  mod_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_ff @(posedge i_clk) begin
    valid_q <= 1'b0;
    ferr_q  <= 1'b0;
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      held_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            sh_q[bit_q] <= rx_s;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave STOP at mid-bit so a start bit right after it is not missed.
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= sh_q;
              held_q  <= sh_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_held_byte = held_q;
  assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mod_midi_rx.sv
// Directed bench for mod_midi_rx at 16 clocks per bit.
module tb_mod_midi_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data, held;
  logic       valid, ferr, busy;

  int n_cmp = 0, n_bad = 0;
  int n_val = 0, n_err = 0, n_both = 0;
  int cyc = 0, t0 = 0, lat = -1;
  logic [7:0] vq[$];

  mod_midi_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_held_byte (held),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        vq.push_back(data);
        n_val++;
        if (lat < 0) lat = cyc - t0;
      end
      if (ferr) n_err++;
      if (valid && ferr) n_both++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    t0 = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  int v0, e0;
  logic [7:0] pop;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_held", held, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // 1: single frame
    send(8'h90, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("t1_nval", n_val, 1);
    pop = vq.pop_front();
    chk("t1_data", pop, 8'h90);
    chk("t1_held", held, 8'h90);
    chk("t1_nerr", n_err, 0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_lat", (lat >= 154 && lat <= 156), 1'b1);

    // 2: back-to-back, no idle gap
    send(8'h90, 1'b1);
    send(8'h3C, 1'b1);
    send(8'h7F, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("t2_nval", n_val, 4);
    pop = vq.pop_front(); chk("t2_d0", pop, 8'h90);
    pop = vq.pop_front(); chk("t2_d1", pop, 8'h3C);
    pop = vq.pop_front(); chk("t2_d2", pop, 8'h7F);
    chk("t2_held", held, 8'h7F);

    // 3: glitch shorter than half a bit
    hold(1'b0, 4);
    chk("t3_busy_start", busy, 1'b1);
    hold(1'b0, 1);
    hold(1'b1, 2 * CPB);
    chk("t3_nval", n_val, 4);
    chk("t3_nerr", n_err, 0);
    chk("t3_busy", busy, 1'b0);
    chk("t3_held", held, 8'h7F);

    // 4: stop bit low then break, recover with 0xA5
    send(8'h55, 1'b0);
    hold(1'b0, 40);
    chk("t4_busy_break", busy, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("t4_nerr", n_err, 1);
    chk("t4_nval", n_val, 4);
    chk("t4_held", held, 8'h7F);
    chk("t4_data", data, 8'h7F);
    chk("t4_busy", busy, 1'b0);
    send(8'hA5, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("t4_nval2", n_val, 5);
    pop = vq.pop_front(); chk("t4_dA5", pop, 8'hA5);
    chk("t4_heldA5", held, 8'hA5);

    // 5: reset in the middle of data bit 4; rest of frame abandoned
    v0 = n_val; e0 = n_err;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(((8'h12 >> i) & 8'h01) != 0, CPB);
    hold(1'b1, CPB / 2);
    chk("t5_busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 4);
    chk("t5_held", held, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_data", data, 8'h00);
    hold(1'b1, 20 * CPB);
    chk("t5_nval", n_val, v0);
    chk("t5_nerr", n_err, e0);
    send(8'h12, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("t5_nval2", n_val, v0 + 1);
    pop = vq.pop_front(); chk("t5_d12", pop, 8'h12);
    chk("t5_held12", held, 8'h12);

    chk("excl", n_both, 0);
    chk("q_empty", vq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
